// File: rtl/key_buf_pkg.sv
// Shared definitions for the keypoint buffer sequencer.
// Holds the state encoding and the default sizes.
package key_buf_pkg;

  localparam int KB_DEPTH  = 100;
  localparam int KB_CNT_W  = 7;
  localparam int KB_DROP_W = 16;

  typedef enum logic [1:0] {
    KB_IDLE  = 2'd0,
    KB_FILL  = 2'd1,
    KB_DRAIN = 2'd2,
    KB_FLUSH = 2'd3
  } kb_state_e;

endpackage

// File: rtl/kb_occ_counter.sv
// Occupancy counter for the keypoint buffer.
// Counts up and down, and clears; it saturates at DEPTH and at 0.
module kb_occ_counter #(
  parameter int DEPTH = 100,
  parameter int CNT_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/key_buffer_ctrl.sv
// Frame sequencer for the keypoint buffer between the ORB extractor and the matcher.
// Handshake: a push/pop strobe moves one keypoint in the same cycle it is high; pop = o_match_valid & i_match_ready.
module key_buffer_ctrl
  import key_buf_pkg::*;
#(
  parameter int DEPTH  = KB_DEPTH,
  parameter int CNT_W  = KB_CNT_W,
  parameter int DROP_W = KB_DROP_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_frame_start,
  input  logic              i_frame_end,
  input  logic              i_abort,
  input  logic              i_feat_valid,
  input  logic              i_match_ready,
  output logic              o_buf_push,
  output logic              o_buf_pop,
  output logic              o_buf_clear,
  output logic              o_match_valid,
  output logic [CNT_W-1:0]  o_count,
  output logic [DROP_W-1:0] o_drop_cnt,
  output logic              o_overrun,
  output logic              o_busy,
  output logic [1:0]        o_state_dbg
);

  localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [DROP_W-1:0] DROP_MAX  = '1;

  kb_state_e         state_q, state_d;
  logic              to_fill_q, to_fill_d;
  logic              pend_q, pend_d;
  logic              clear_q, clear_d;
  logic              overrun_q, overrun_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              push, pop, mvalid, drop_inc, cnt_clr, start_eff;
  logic [CNT_W-1:0]  count;

  kb_occ_counter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_occ (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .inc_i   (push),
    .dec_i   (pop),
    .clr_i   (cnt_clr),
    .count_o (count)
  );

  // A start that coincided with frame end acts one cycle later, and only while still draining.
  assign start_eff = i_frame_start | (pend_q & (state_q == KB_DRAIN));

  always_comb begin
    state_d   = state_q;
    to_fill_d = to_fill_q;
    pend_d    = 1'b0;
    overrun_d = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    mvalid    = 1'b0;
    drop_inc  = 1'b0;
    cnt_clr   = 1'b0;
    case (state_q)
      KB_IDLE: begin
        if (i_frame_start) state_d = KB_FILL;
      end
      KB_FILL: begin
        push     = i_feat_valid & (count != CNT_DEPTH);
        drop_inc = i_feat_valid & (count == CNT_DEPTH);
        if (i_frame_end) begin
          state_d = ((count != '0) || push) ? KB_DRAIN : KB_IDLE;
          pend_d  = i_frame_start & ((count != '0) || push);
        end
      end
      KB_DRAIN: begin
        mvalid   = (count != '0);
        pop      = mvalid & i_match_ready;
        drop_inc = i_feat_valid;
        if (start_eff) begin
          state_d   = KB_FLUSH;
          to_fill_d = 1'b1;
          overrun_d = 1'b1;
        end else if ((count == '0) || (pop && (count == CNT_W'(1)))) begin
          state_d = KB_IDLE;
        end
      end
      default: begin
        cnt_clr   = 1'b1;
        drop_inc  = i_feat_valid;
        state_d   = to_fill_q ? KB_FILL : KB_IDLE;
        to_fill_d = 1'b0;
      end
    endcase
    if (i_abort) begin
      state_d   = KB_FLUSH;
      to_fill_d = 1'b0;
      pend_d    = 1'b0;
      overrun_d = 1'b0;
    end
  end

  assign clear_d = (state_d == KB_FLUSH);
  assign drop_d  = (drop_inc && (drop_q != DROP_MAX)) ? drop_q + 1'b1 : drop_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= KB_IDLE;
      to_fill_q <= 1'b0;
      pend_q    <= 1'b0;
      clear_q   <= 1'b0;
      overrun_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      to_fill_q <= to_fill_d;
      pend_q    <= pend_d;
      clear_q   <= clear_d;
      overrun_q <= overrun_d;
      drop_q    <= drop_d;
    end
  end

  assign o_buf_push    = push;
  assign o_buf_pop     = pop;
  assign o_buf_clear   = clear_q;
  assign o_match_valid = mvalid;
  assign o_count       = count;
  assign o_drop_cnt    = drop_q;
  assign o_overrun     = overrun_q;
  assign o_busy        = (state_q != KB_IDLE);
  assign o_state_dbg   = state_q;

endmodule

// File: tb/tb_key_buffer_ctrl.sv
// Directed bench for key_buffer_ctrl (DEPTH=4) with an event scoreboard on push/pop/clear/overrun.
module tb_key_buffer_ctrl;

  localparam int W = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0, frame_end = 1'b0, abort = 1'b0;
  logic        feat_valid = 1'b0, match_ready = 1'b0;
  logic        buf_push, buf_pop, buf_clear, match_valid, overrun, busy;
  logic [2:0]  count;
  logic [15:0] drop_cnt;
  logic [1:0]  state_dbg;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_act, mon_exp;

  key_buffer_ctrl #(.DEPTH(4), .CNT_W(3), .DROP_W(16)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_frame_start (frame_start),
    .i_frame_end   (frame_end),
    .i_abort       (abort),
    .i_feat_valid  (feat_valid),
    .i_match_ready (match_ready),
    .o_buf_push    (buf_push),
    .o_buf_pop     (buf_pop),
    .o_buf_clear   (buf_clear),
    .o_match_valid (match_valid),
    .o_count       (count),
    .o_drop_cnt    (drop_cnt),
    .o_overrun     (overrun),
    .o_busy        (busy),
    .o_state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ev(logic p, logic po, logic c, logic o, logic [2:0] n);
    return {p, po, c, o, n};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_feats(input int n, input int first_cnt, input int accept);
    feat_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i < accept) exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 3'(first_cnt + i)));
      step();
    end
    feat_valid = 1'b0;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1; step(); frame_start = 1'b0;
  endtask

  task automatic pulse_end();
    frame_end = 1'b1; step(); frame_end = 1'b0;
  endtask

  // monitor: every strobe cycle pops one expected event
  always @(negedge clk) begin
    if (!rst && (buf_push || buf_pop || buf_clear || overrun)) begin
      mon_act = {buf_push, buf_pop, buf_clear, overrun, count};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL event_unexpected: got %b expected none at %0t", mon_act, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          miscompares++;
          $display("FAIL event: got %b expected %b (push,pop,clr,ovr,cnt) at %0t",
                   mon_act, mon_exp, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    step(); step();
    check("rst_count", count, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_clear", buf_clear, 0);
    check("rst_mvalid", match_valid, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    step();

    // basic frame: 3 keypoints then drained back to back
    match_ready = 1'b1;
    pulse_start();
    check("t1_state_fill", state_dbg, 1);
    push_feats(3, 0, 3);
    check("t1_count3", count, 3);
    pulse_end();
    check("t1_state_drain", state_dbg, 2);
    check("t1_mvalid", match_valid, 1);
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, 3'd3));
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, 3'd2));
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, 3'd1));
    step(); step(); step();
    check("t1_idle", busy, 0);
    check("t1_count0", count, 0);
    check("t1_drop0", drop_cnt, 0);
    match_ready = 1'b0;

    // overflow: 6 keypoints into a 4-deep buffer
    pulse_start();
    push_feats(6, 0, 4);
    check("t2_count4", count, 4);
    check("t2_drop2", drop_cnt, 2);
    pulse_end();
    check("t2_state_drain", state_dbg, 2);
    check("t2_mvalid", match_valid, 1);

    // asynchronous reset mid-drain
    #3 rst = 1'b1;
    #1;
    check("rst_mid_count", count, 0);
    check("rst_mid_mvalid", match_valid, 0);
    check("rst_mid_state", state_dbg, 0);
    check("rst_mid_clear", buf_clear, 0);
    check("rst_mid_drop", drop_cnt, 0);
    step();
    rst = 1'b0;
    step();

    // frame start while draining -> overrun, flush, refill
    pulse_start();
    push_feats(2, 0, 2);
    pulse_end();
    check("t3_count2", count, 2);
    feat_valid = 1'b1; step(); feat_valid = 1'b0;
    check("t3_drain_drop", drop_cnt, 1);
    exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b1, 3'd2));
    pulse_start();
    check("t3_overrun", overrun, 1);
    check("t3_clear", buf_clear, 1);
    check("t3_state_flush", state_dbg, 3);
    step();
    check("t3_state_fill", state_dbg, 1);
    check("t3_count0", count, 0);
    check("t3_clear_off", buf_clear, 0);
    check("t3_overrun_off", overrun, 0);
    push_feats(1, 0, 1);
    check("t3_refill", count, 1);
    match_ready = 1'b1;
    pulse_end();
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, 3'd1));
    step();
    check("t3_idle", busy, 0);
    match_ready = 1'b0;

    // empty frame goes straight back to idle
    pulse_start();
    check("t4_mvalid_fill", match_valid, 0);
    pulse_end();
    check("t4_idle", busy, 0);
    check("t4_mvalid", match_valid, 0);
    check("t4_count", count, 0);

    // abort during fill
    pulse_start();
    push_feats(3, 0, 3);
    check("t5_count3", count, 3);
    exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 3'd3));
    abort = 1'b1; step(); abort = 1'b0;
    check("t5_state_flush", state_dbg, 3);
    check("t5_clear", buf_clear, 1);
    check("t5_overrun", overrun, 0);
    step();
    check("t5_idle", busy, 0);
    check("t5_count0", count, 0);
    check("t5_clear_off", buf_clear, 0);

    // frame end and start together: drain first, then overrun
    pulse_start();
    push_feats(1, 0, 1);
    frame_end = 1'b1; frame_start = 1'b1; step();
    frame_end = 1'b0; frame_start = 1'b0;
    check("t6_state_drain", state_dbg, 2);
    exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b1, 3'd1));
    step();
    check("t6_overrun", overrun, 1);
    check("t6_state_flush", state_dbg, 3);
    step();
    check("t6_state_fill", state_dbg, 1);
    pulse_end();
    check("t6_idle", busy, 0);
    check("t6_drop", drop_cnt, 1);

    step(); step();
    check("events_outstanding", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
